id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the 15+1 entry register file.
- Captures the two read ports, resolves the same-cycle write-back hazard and R15 reads, and latches operands, immediate, destination and control into the EX stage.
- Supports stall (hold) and flush (bubble) from the hazard/branch-predictor logic, and emits a valid bit so EX/MEM can squash bubbles.

Parameters:
- WIDTH, 32, datapath width of operands, immediate and write-back data.
- CTRL_W, 12, width of the opaque decoded control bundle passed to EX.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- reset  in  1  asynchronous, active-low; clears all state.
- stall_d  in  1  hold current EX contents (decode is frozen).
- flush_e  in  1  insert bubble into EX (branch mispredict / load-use).
- valid_d  in  1  decode slot holds a real instruction.
- src0_d, src1_d  in  4 each  register indices driven to the register file read selects.
- rf_out0, rf_out1  in  WIDTH each  register file read data for src0_d/src1_d.
- pc_plus8_d  in  WIDTH  architectural R15 value for this instruction.
- imm_d  in  WIDTH  extended immediate.
- dest_d  in  4  destination register index.
- ctrl_d  in  CTRL_W  decoded control bundle.
- wb_we  in  1  write-back enable (same signal as the register file write enable).
- wb_dest  in  4  write-back destination index.
- wb_data  in  WIDTH  write-back data.
- op0_e, op1_e  out  WIDTH each  latched operands.
- imm_e  out  WIDTH  latched immediate.
- dest_e  out  4  latched destination.
- src0_e, src1_e  out  4 each  latched source indices, for the EX forwarding unit.
- ctrl_e  out  CTRL_W  latched control.
- valid_e  out  1  EX slot valid.

Behaviour:
- Reset (reset=0, asynchronous): every output = 0, including valid_e=0 and ctrl_e=0. Takes effect immediately, mid-stall or mid-flush; the first capture happens on the first rising edge after release.
- Operand select, combinational, per port n (priority top-down):
  - src_n_d==15: pc_plus8_d. Write-back is never bypassed to R15.
  - wb_we=1 and wb_dest==src_n_d: wb_data. This covers the register file writing on the same edge that EX captures.
  - Otherwise: rf_out_n.
- Edge behaviour (rising clk, priority top-down):
  - flush_e=1: valid_e=0, ctrl_e=0. op/imm/dest/src registers keep their old values (don't-care). Flush wins over stall.
  - stall_d=1: all outputs hold. A write-back during the stall is not visible in held operands; the EX forwarding unit covers that case via src0_e/src1_e.
  - Otherwise: capture. op0_e/op1_e = selected operands, imm_e=imm_d, dest_e=dest_d, src*_e=src*_d, ctrl_e = valid_d ? ctrl_d : 0, valid_e=valid_d.
- Latency: exactly 1 cycle from decode inputs to EX outputs; no combinational path from inputs to outputs.
- Invalid decode slots (valid_d=0) still capture data fields but zero ctrl_e, so no side effects occur downstream.
- Widths: all index compares are 4-bit exact. No arithmetic is performed in this block.

Decomposition:
- Shared package: the R15 index constant (4'd15), CTRL_W, and the control-bundle field offsets used by EX.
- One natural sub-module: operand_bypass_mux (src index, rf data, pc_plus8, wb_we/dest/data -> operand), instantiated twice.
- Flop logic stays in the top module.

Test Plan:
- Reset: hold reset=0 with random inputs toggling -> all outputs 0. Release, then drive src0=3 with rf_out0=0x11, valid_d=1 -> next edge op0_e=0x11, valid_e=1.
- Same-cycle bypass: src1_d=5, rf_out1=0xAAAA0000, wb_we=1, wb_dest=5, wb_data=0x12345678 -> op1_e=0x12345678. Repeat with wb_we=0 -> op1_e=0xAAAA0000.
- R15 read: src0_d=15, pc_plus8_d=0x108, wb_we=1, wb_dest=15, wb_data=0xDEAD -> op0_e=0x108.
- Stall: capture an instruction, then stall_d=1 for 3 cycles while inputs change -> outputs constant. Drop stall -> new values appear after 1 edge.
- Flush vs stall: stall_d=1 and flush_e=1 together with ctrl_e previously 0x5A5 -> valid_e=0, ctrl_e=0 after the edge.
- Invalid slot: valid_d=0, ctrl_d=0xFFF -> ctrl_e=0, valid_e=0; dest_e and imm_e still capture.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants and types for the ID/EX operand stage and its consumers.
package id_ex_operand_stage_pkg;

    typedef logic [3:0] reg_idx_t;

    // R15 reads return the architectural PC+8 and are never write-back bypassed.
    localparam reg_idx_t REG_PC = 4'd15;

    localparam int CTRL_W = 12;

    // Control-bundle field offsets, decoded by EX.
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_MEM_RD     = 4;
    localparam int CTRL_MEM_WR     = 5;
    localparam int CTRL_REG_WE     = 6;
    localparam int CTRL_SET_FLAGS  = 7;
    localparam int CTRL_SHIFT_LSB  = 8;
    localparam int CTRL_SHIFT_W    = 4;

    function automatic logic is_pc_reg(input reg_idx_t idx);
        return idx == REG_PC;
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode, write-back and EX-side signals of the ID/EX operand stage.
interface id_ex_operand_stage_if
    import id_ex_operand_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = id_ex_operand_stage_pkg::CTRL_W
);
    logic              stall_d;
    logic              flush_e;
    logic              valid_d;
    reg_idx_t          src0_d;
    reg_idx_t          src1_d;
    logic [WIDTH-1:0]  rf_out0;
    logic [WIDTH-1:0]  rf_out1;
    logic [WIDTH-1:0]  pc_plus8_d;
    logic [WIDTH-1:0]  imm_d;
    reg_idx_t          dest_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              wb_we;
    reg_idx_t          wb_dest;
    logic [WIDTH-1:0]  wb_data;

    logic [WIDTH-1:0]  op0_e;
    logic [WIDTH-1:0]  op1_e;
    logic [WIDTH-1:0]  imm_e;
    reg_idx_t          dest_e;
    reg_idx_t          src0_e;
    reg_idx_t          src1_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic              valid_e;

    modport master (
        output stall_d, flush_e, valid_d, src0_d, src1_d, rf_out0, rf_out1,
               pc_plus8_d, imm_d, dest_d, ctrl_d, wb_we, wb_dest, wb_data,
        input  op0_e, op1_e, imm_e, dest_e, src0_e, src1_e, ctrl_e, valid_e
    );

    modport slave (
        input  stall_d, flush_e, valid_d, src0_d, src1_d, rf_out0, rf_out1,
               pc_plus8_d, imm_d, dest_d, ctrl_d, wb_we, wb_dest, wb_data,
        output op0_e, op1_e, imm_e, dest_e, src0_e, src1_e, ctrl_e, valid_e
    );

endinterface

// File: rtl/id_ex_operand_stage_operand_bypass_mux.sv
// Selects one decode operand: R15 -> PC+8, same-cycle write-back hit -> wb data,
// otherwise register file read data.
module operand_bypass_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  reg_idx_t         i_src,
    input  logic [WIDTH-1:0] i_rf_data,
    input  logic [WIDTH-1:0] i_pc_plus8,
    input  logic             i_wb_we,
    input  reg_idx_t         i_wb_dest,
    input  logic [WIDTH-1:0] i_wb_data,
    output logic [WIDTH-1:0] o_operand
);

    // Priority select: PC read first, then write-back bypass, then register file.
    always_comb begin
        o_operand = i_rf_data;
        if (is_pc_reg(i_src)) begin
            o_operand = i_pc_plus8;
        end else if (i_wb_we && (i_wb_dest == i_src)) begin
            o_operand = i_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: resolves operands and latches decode state into EX,
// with stall (hold) and flush (bubble) control.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = id_ex_operand_stage_pkg::CTRL_W
) (
    input logic                   clk,
    input logic                   reset,
    id_ex_operand_stage_if.slave  bus
);

    logic [WIDTH-1:0]  w_op0;
    logic [WIDTH-1:0]  w_op1;

    logic [WIDTH-1:0]  r_op0;
    logic [WIDTH-1:0]  r_op1;
    logic [WIDTH-1:0]  r_imm;
    reg_idx_t          r_dest;
    reg_idx_t          r_src0;
    reg_idx_t          r_src1;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_valid;

    operand_bypass_mux #(.WIDTH(WIDTH)) u_mux0 (
        .i_src      (bus.src0_d),
        .i_rf_data  (bus.rf_out0),
        .i_pc_plus8 (bus.pc_plus8_d),
        .i_wb_we    (bus.wb_we),
        .i_wb_dest  (bus.wb_dest),
        .i_wb_data  (bus.wb_data),
        .o_operand  (w_op0)
    );

    operand_bypass_mux #(.WIDTH(WIDTH)) u_mux1 (
        .i_src      (bus.src1_d),
        .i_rf_data  (bus.rf_out1),
        .i_pc_plus8 (bus.pc_plus8_d),
        .i_wb_we    (bus.wb_we),
        .i_wb_dest  (bus.wb_dest),
        .i_wb_data  (bus.wb_data),
        .o_operand  (w_op1)
    );

    // EX register: flush clears valid/ctrl only (data is don't-care in a bubble),
    // stall holds everything, otherwise capture the decode slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op0   <= '0;
            r_op1   <= '0;
            r_imm   <= '0;
            r_dest  <= '0;
            r_src0  <= '0;
            r_src1  <= '0;
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (bus.flush_e) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (!bus.stall_d) begin
            r_op0   <= w_op0;
            r_op1   <= w_op1;
            r_imm   <= bus.imm_d;
            r_dest  <= bus.dest_d;
            r_src0  <= bus.src0_d;
            r_src1  <= bus.src1_d;
            r_ctrl  <= bus.valid_d ? bus.ctrl_d : '0;
            r_valid <= bus.valid_d;
        end
    end

    assign bus.op0_e   = r_op0;
    assign bus.op1_e   = r_op1;
    assign bus.imm_e   = r_imm;
    assign bus.dest_e  = r_dest;
    assign bus.src0_e  = r_src0;
    assign bus.src1_e  = r_src1;
    assign bus.ctrl_e  = r_ctrl;
    assign bus.valid_e = r_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected EX contents are queued
// when a decode slot is driven and compared one edge later.
module tb_id_ex_operand_stage;

    localparam int W  = 32;
    localparam int CW = 12;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    id_ex_operand_stage_if #(.WIDTH(W), .CTRL_W(CW)) bus ();

    id_ex_operand_stage #(.WIDTH(W), .CTRL_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  op0;
        logic [W-1:0]  op1;
        logic [W-1:0]  imm;
        logic [3:0]    dest;
        logic [3:0]    src0;
        logic [3:0]    src1;
        logic [CW-1:0] ctrl;
        logic          valid;
    } ex_t;

    ex_t model;
    ex_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_operand(input logic [3:0] src, input logic [W-1:0] rf);
        if (src == 4'd15) return bus.pc_plus8_d;
        if (bus.wb_we && bus.wb_dest == src) return bus.wb_data;
        return rf;
    endfunction

    task automatic clear_model();
        model = '{op0: '0, op1: '0, imm: '0, dest: '0, src0: '0, src1: '0, ctrl: '0, valid: 1'b0};
    endtask

    task automatic clear_inputs();
        bus.stall_d = 1'b0; bus.flush_e = 1'b0; bus.valid_d = 1'b0;
        bus.src0_d = '0; bus.src1_d = '0; bus.rf_out0 = '0; bus.rf_out1 = '0;
        bus.pc_plus8_d = '0; bus.imm_d = '0; bus.dest_d = '0; bus.ctrl_d = '0;
        bus.wb_we = 1'b0; bus.wb_dest = '0; bus.wb_data = '0;
    endtask

    task automatic rand_data();
        bus.src0_d = 4'($urandom_range(0, 15));
        bus.src1_d = 4'($urandom_range(0, 15));
        bus.rf_out0 = $urandom; bus.rf_out1 = $urandom;
        bus.pc_plus8_d = $urandom; bus.imm_d = $urandom;
        bus.dest_d = 4'($urandom_range(0, 15));
        bus.ctrl_d = CW'($urandom);
        bus.valid_d = 1'($urandom);
        bus.wb_we = 1'($urandom);
        bus.wb_data = $urandom;
        case ($urandom_range(0, 2))
            0: bus.wb_dest = bus.src0_d;
            1: bus.wb_dest = bus.src1_d;
            default: bus.wb_dest = 4'($urandom_range(0, 15));
        endcase
    endtask

    task automatic compare(input string tag, input ex_t e);
        check({tag, ".op0"},   bus.op0_e, e.op0);
        check({tag, ".op1"},   bus.op1_e, e.op1);
        check({tag, ".imm"},   bus.imm_e, e.imm);
        check({tag, ".dest"},  32'(bus.dest_e), 32'(e.dest));
        check({tag, ".src0"},  32'(bus.src0_e), 32'(e.src0));
        check({tag, ".src1"},  32'(bus.src1_e), 32'(e.src1));
        check({tag, ".ctrl"},  32'(bus.ctrl_e), 32'(e.ctrl));
        check({tag, ".valid"}, 32'(bus.valid_e), 32'(e.valid));
    endtask

    // Predict the next EX contents from the current inputs, clock once, compare.
    task automatic step(input string tag);
        ex_t got;
        if (bus.flush_e) begin
            model.ctrl = '0;
            model.valid = 1'b0;
        end else if (!bus.stall_d) begin
            model.op0 = ref_operand(bus.src0_d, bus.rf_out0);
            model.op1 = ref_operand(bus.src1_d, bus.rf_out1);
            model.imm = bus.imm_d;
            model.dest = bus.dest_d;
            model.src0 = bus.src0_d;
            model.src1 = bus.src1_d;
            model.ctrl = bus.valid_d ? bus.ctrl_d : '0;
            model.valid = bus.valid_d;
        end
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            compare(tag, got);
        end
    endtask

    ex_t zero_e;

    initial begin
        clear_inputs();
        clear_model();
        zero_e = model;

        // Reset held with inputs toggling: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            rand_data();
            bus.stall_d = 1'($urandom);
            bus.flush_e = 1'($urandom);
            @(posedge clk);
            #1;
            compare("rst_hold", zero_e);
        end

        clear_inputs();
        reset = 1'b1;
        #2;

        // First capture after release.
        bus.valid_d = 1'b1; bus.src0_d = 4'd3; bus.rf_out0 = 32'h11; bus.ctrl_d = 12'h0A1;
        bus.imm_d = 32'h44; bus.dest_d = 4'd2;
        step("first");

        // Same-cycle write-back bypass, then same inputs without wb_we.
        bus.src1_d = 4'd5; bus.rf_out1 = 32'hAAAA0000;
        bus.wb_we = 1'b1; bus.wb_dest = 4'd5; bus.wb_data = 32'h12345678;
        step("bypass_on");
        bus.wb_we = 1'b0;
        step("bypass_off");

        // R15 ignores the write-back to 15.
        bus.src0_d = 4'd15; bus.pc_plus8_d = 32'h108;
        bus.wb_we = 1'b1; bus.wb_dest = 4'd15; bus.wb_data = 32'hDEAD;
        step("r15");

        // Stall: hold for three cycles while inputs change, then release.
        clear_inputs();
        bus.valid_d = 1'b1; bus.src0_d = 4'd1; bus.src1_d = 4'd2;
        bus.rf_out0 = 32'hCAFE0001; bus.rf_out1 = 32'hCAFE0002; bus.ctrl_d = 12'h123;
        step("stall_cap");
        for (int i = 0; i < 3; i++) begin
            rand_data();
            bus.stall_d = 1'b1;
            step("stall_hold");
        end
        bus.stall_d = 1'b0;
        step("stall_rel");

        // Flush wins over stall.
        clear_inputs();
        bus.valid_d = 1'b1; bus.ctrl_d = 12'h5A5; bus.imm_d = 32'h77;
        step("pre_flush");
        rand_data();
        bus.stall_d = 1'b1; bus.flush_e = 1'b1;
        step("flush_stall");

        // Invalid slot: data captured, control zeroed.
        clear_inputs();
        bus.valid_d = 1'b0; bus.ctrl_d = 12'hFFF; bus.imm_d = 32'hBEEF; bus.dest_d = 4'd9;
        step("invalid");

        // Flush alone.
        bus.valid_d = 1'b1; bus.ctrl_d = 12'h3C3; step("flush_pre");
        bus.flush_e = 1'b1; step("flush_only");

        // Asynchronous reset mid-stall, away from the clock edge.
        clear_inputs();
        bus.valid_d = 1'b1; bus.ctrl_d = 12'h0F0; bus.rf_out0 = 32'h99;
        step("arst_cap");
        bus.stall_d = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        clear_model();
        compare("arst_now", zero_e);
        @(negedge clk);
        reset = 1'b1;
        bus.stall_d = 1'b0;
        bus.src0_d = 4'd7; bus.rf_out0 = 32'h5555; bus.ctrl_d = 12'h00E;
        step("arst_rel");

        // Random traffic with frequent write-back collisions.
        for (int i = 0; i < 60; i++) begin
            rand_data();
            bus.stall_d = ($urandom_range(0, 3) == 0);
            bus.flush_e = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
